instr_fetch_queue: RTL and testbench

//  Fetch stage upstream of instruction decode. Reads instructions one byte per

---
 rtl/instr_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: assembles big-endian 32-bit words from a byte-wide
// store and queues {word, pc} for decode; redirects flush and restart fetch.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         mem_rd_o,
  output logic [31:0]                  mem_addr_o,
  input  logic [7:0]                   mem_rdata_i,
  input  logic                         mem_valid_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         instr_valid_o,
  output logic [31:0]                  instr_o,
  output logic [31:0]                  instr_pc_o,
  input  logic                         instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        word_q, word_d;
  logic               mem_rd_q, mem_rd_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             fifo_q [DEPTH];

  logic               push;
  logic               pop;
  logic               full;
  logic               accept;
  entry_t             push_entry;

  // Next-state: byte assembly, hold-on-full, redirect flush (highest priority)
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    push       = 1'b0;
    pop        = 1'b0;
    full       = (count_q == CNT_W'(DEPTH));
    accept     = mem_rd_q & mem_valid_i;

    if (redirect_i) begin
      state_d    = ST_FETCH;
      fetch_pc_d = redirect_pc_i;
      byte_idx_d = 2'd0;
      word_d     = 32'd0;
    end else begin
      pop = (count_q != '0) & instr_ready_i;
      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            word_d = {word_q[23:0], mem_rdata_i};
            if (byte_idx_q == 2'd3) begin
              byte_idx_d = 2'd0;
              // A full queue blocks the push even if a pop happens this edge
              if (!full) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
              end else begin
                state_d = ST_HOLD;
              end
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!full) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end

    push_entry = '{word: word_d, pc: fetch_pc_q};
    mem_rd_d   = (state_d == ST_FETCH);
    mem_addr_d = fetch_pc_d + 32'(byte_idx_d);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
      end
    end
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = fifo_q[rd_ptr_q].word;
  assign instr_pc_o    = fifo_q[rd_ptr_q].pc;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a cycle-level scoreboard of the
// expected queue contents, fetch address and request strobe.
module tb_instr_fetch_queue;

  localparam int          DEPTH_TB = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready;
  logic [2:0]  count;

  int nchecks = 0;
  int nerrors = 0;
  int cyc     = 0;
  int mem_mode = 0;

  instr_fetch_queue #(.DEPTH(DEPTH_TB), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .mem_valid_i(mem_valid),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h20;
      32'd1:   return 8'h08;
      32'd2:   return 8'h00;
      32'd3:   return 8'h05;
      default: return 8'(a[7:0] * 8'd13 + a[31:24] + 8'h31);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    return {mem_byte(pc), mem_byte(pc + 32'd1), mem_byte(pc + 32'd2), mem_byte(pc + 32'd3)};
  endfunction

  // Byte store: combinational data, grant pattern chosen by mem_mode
  assign mem_rdata = mem_byte(mem_addr);
  assign mem_valid = (mem_mode == 0) || (cyc % 3 == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_held;
  logic [31:0] m_pc;
  int          m_bidx;
  logic        m_rd;

  // Scoreboard: compare post-edge state, then predict the coming edge
  always @(negedge clk) begin
    int   sz;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_held = 1'b0;
      m_pc   = RST_PC;
      m_bidx = 0;
      m_rd   = 1'b0;
    end else begin
      check("sb_mem_rd", 32'(mem_rd), 32'(m_rd));
      if (m_rd) check("sb_mem_addr", mem_addr, m_pc + 32'(m_bidx));
      check("sb_count", 32'(count), 32'(mq.size()));
      check("sb_instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("sb_instr", instr, mq[0].word);
        check("sb_instr_pc", instr_pc, mq[0].pc);
      end
      if (redirect) begin
        mq.delete();
        m_held = 1'b0;
        m_pc   = redirect_pc;
        m_bidx = 0;
        m_rd   = 1'b1;
      end else begin
        sz = mq.size();
        if (sz > 0 && ready) void'(mq.pop_front());
        e.word = exp_word(m_pc);
        e.pc   = m_pc;
        if (m_held) begin
          if (sz < DEPTH_TB) begin
            mq.push_back(e);
            m_held = 1'b0;
            m_pc   = m_pc + 32'd4;
          end
        end else if (m_rd && mem_valid) begin
          m_bidx++;
          if (m_bidx == 4) begin
            m_bidx = 0;
            if (sz < DEPTH_TB) begin
              mq.push_back(e);
              m_pc = m_pc + 32'd4;
            end else begin
              m_held = 1'b1;
            end
          end
        end
        m_rd = !m_held;
      end
    end
  end

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (!instr_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check({tag, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int n;
    int t_a;
    int t_b;
    rst_n       = 1'b0;
    ready       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    mem_mode    = 0;
    repeat (3) @(negedge clk);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", mem_addr, RST_PC);
    check("rst_count", 32'(count), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // T1: first word latency and content
    @(posedge clk); #1 rst_n = 1'b1; ready = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (!instr_valid && edges < 20);
    check("t1_latency_edges", 32'(edges), 32'd5);
    check("t1_instr", instr, 32'h2008_0005);
    check("t1_instr_pc", instr_pc, 32'd0);
    repeat (20) @(posedge clk);

    // T2: fill to DEPTH, fifth word held, single pop refills
    #1 ready = 1'b0;
    n = 0;
    while (!(count == 3'd4 && !mem_rd) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("t2_full_count", 32'(count), 32'd4);
    check("t2_hold_mem_rd", 32'(mem_rd), 32'd0);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("t2_after_pop", 32'(count), 32'd3);
    @(negedge clk);
    check("t2_refill", 32'(count), 32'd4);
    check("t2_refetch_rd", 32'(mem_rd), 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    repeat (30) @(posedge clk);

    // T3: grant every third cycle
    #1 mem_mode = 1;
    wait_valid("t3_w1", 60);
    @(posedge clk); #1;
    wait_valid("t3_w2", 60);
    t_a = cyc;
    @(posedge clk); #1;
    wait_valid("t3_w3", 60);
    t_b = cyc;
    check("t3_cycles_per_word", 32'(t_b - t_a), 32'd12);

    // T4: redirect mid-word with two queued
    @(posedge clk); #1 mem_mode = 0; ready = 1'b0; redirect = 1'b1; redirect_pc = 32'd0;
    @(posedge clk); #1 redirect = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("t4_two_queued", 32'(count), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1 redirect = 1'b0;
    check("t4_flush_count", 32'(count), 32'd0);
    check("t4_mem_addr", mem_addr, 32'h40);
    check("t4_mem_rd", 32'(mem_rd), 32'd1);
    ready = 1'b1;
    wait_valid("t4_first", 40);
    check("t4_instr_pc", instr_pc, 32'h40);
    check("t4_instr", instr, exp_word(32'h40));

    // T5: address wrap, then redirect with concurrent pop to an unaligned target
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1 redirect = 1'b0;
    wait_valid("t5_top", 40);
    check("t5_top_pc", instr_pc, 32'hFFFF_FFFC);
    check("t5_top_instr", instr, exp_word(32'hFFFF_FFFC));
    @(posedge clk); #1;
    wait_valid("t5_wrap", 40);
    check("t5_wrap_pc", instr_pc, 32'h0000_0000);
    @(posedge clk); #1 ready = 1'b0;
    n = 0;
    while (count < 3'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    @(posedge clk); #1 redirect = 1'b0;
    check("t5_flush_count", 32'(count), 32'd0);
    check("t5_flush_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t5_no_underflow", 32'(count), 32'd0);
    wait_valid("t5_unaligned", 40);
    check("t5_unaligned_pc", instr_pc, 32'h103);
    check("t5_unaligned_instr", instr, exp_word(32'h103));

    // Back-to-back redirects: last target wins
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1 redirect_pc = 32'h300;
    @(posedge clk); #1 redirect = 1'b0;
    wait_valid("b2b", 40);
    check("b2b_pc", instr_pc, 32'h300);

    // T6: async reset mid-word with three queued
    @(posedge clk); #1 ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    @(posedge clk); #1 redirect = 1'b0;
    n = 0;
    while (count != 3'd3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_three_queued", 32'(count), 32'd3);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mem_rd", 32'(mem_rd), 32'd0);
    check("t6_mem_addr", mem_addr, RST_PC);
    check("t6_count", 32'(count), 32'd0);
    check("t6_instr_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", instr, 32'd0);
    check("t6_instr_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; ready = 1'b1;
    wait_valid("t6_restart", 40);
    check("t6_restart_pc", instr_pc, RST_PC);
    check("t6_restart_instr", instr, 32'h2008_0005);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
